// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The optional leading-zero blanking is enabled with BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

    localparam int BIN_W_DEF  = 12;
    localparam int DIGITS_DEF = 4;
    localparam int NIB_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit digits_ok(input int bin_w, input int digits);
        longint p10;
        longint max_bin;
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            p10 = p10 * 10;
        end
        max_bin = (longint'(1) << bin_w) - 1;
        return p10 > max_bin;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit of 5 or more.
// An input digit is at most 9, so the 4-bit sum never carries out.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [NIB_W-1:0] i_nib,
    output logic [NIB_W-1:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one binary bit per clock, start/busy/done handshake.
// Define BIN2BCD_BLANK_EN to register leading-zero blank flags alongside bcd_out.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_mask
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (!digits_ok(BIN_W, DIGITS)) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small to represent 2**BIN_W-1");
        end
    endgenerate

    state_t             r_state;
    logic [SR_W-1:0]    r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;

    logic [SR_W-1:0]    w_corr;
    logic [SR_W-1:0]    w_shift_next;
    logic [BCD_W-1:0]   w_bcd_next;
    logic               w_last_shift;

    // Binary field passes through untouched; every BCD nibble is corrected before the shift.
    assign w_corr[BIN_W-1:0] = r_shift[BIN_W-1:0];

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_nib (r_shift[BIN_W + 4*g +: 4]),
                .o_nib (w_corr[BIN_W + 4*g +: 4])
            );
        end
    endgenerate

    assign w_shift_next = w_corr << 1;
    assign w_bcd_next   = w_shift_next[SR_W-1 -: BCD_W];
    assign w_last_shift = (r_state == SHIFT) && (r_cnt == CNT_ONE);

    // The result is captured on the final shift so bcd_out is already valid
    // in the cycle where done is high (the DONE state).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift <= {{BCD_W{1'b0}}, bin_in};
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt - CNT_ONE;
                    if (w_last_shift) begin
                        r_bcd   <= w_bcd_next;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;
    logic              w_run;

    // Walk down from the top digit; digit 0 is never blanked so zero shows as "0".
    always_comb begin
        w_blank_next = '0;
        w_run        = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run           = w_run && (w_bcd_next[4*i +: 4] == 4'd0);
            w_blank_next[i] = w_run;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blank <= '0;
        end else if (w_last_shift) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank_mask = r_blank;
`else
    assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected results queued at start, checked on done.
// Blank-mask expectations follow BIN2BCD_BLANK_EN.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [11:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  mask;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   last_t0  = 0;

`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    bin2bcd_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .blank_mask (blank_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_mask(input int v);
        if (!BLANK_ON) return 4'b0000;
        return {v < 1000, v < 100, v < 10, 1'b0};
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued start.
    always @(negedge clk) begin
        if (reset_n && done) begin
            exp_t e;
            done_cnt++;
            check("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("bcd_out", bcd_out, e.bcd);
                check("blank_mask", blank_mask, e.mask);
                check("latency", cyc - e.t0, 13);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Called at a negedge; returns at the negedge one cycle after the start cycle.
    task automatic start_conv(input logic [11:0] v, input logic [15:0] e_bcd, input logic [3:0] e_mask);
        wait_idle();
        start   = 1'b1;
        bin_in  = v;
        last_t0 = cyc;
        sb.push_back('{bcd: e_bcd, mask: e_mask, t0: cyc});
        @(negedge clk);
        start  = 1'b0;
        bin_in = 12'($urandom);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int t_first;

        reset_n = 1'b0;
        start   = 1'b0;
        bin_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_blank", blank_mask, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-scale value, with the busy profile traced cycle by cycle.
        start  = 1'b1;
        bin_in = 12'd4095;
        sb.push_back('{bcd: 16'h4095, mask: 4'b0000, t0: cyc});
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("busy_%0d", k), busy, 1);
        end
        @(negedge clk);
        check("busy_14", busy, 0);

        start_conv(12'd0, 16'h0000, BLANK_ON ? 4'b1110 : 4'b0000);

        // Second start during SHIFT must be ignored.
        wait_idle();
        d0 = done_cnt;
        start_conv(12'd1234, 16'h1234, 4'b0000);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 12'd999;
        @(negedge clk);
        start  = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("single_done", done_cnt - d0, 1);
        check("bcd_hold", bcd_out, 16'h1234);

        // Back-to-back: second start in the cycle right after done.
        start_conv(12'd1234, 16'h1234, 4'b0000);
        t_first = last_t0;
        start_conv(12'd7, 16'h0007, BLANK_ON ? 4'b1110 : 4'b0000);
        check("b2b_spacing", last_t0 - t_first, 14);

        // Asynchronous reset in the middle of a conversion.
        start_conv(12'd4095, 16'h4095, 4'b0000);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_bcd", bcd_out, 0);
        check("mid_rst_blank", blank_mask, 0);
        sb.delete();
        d0 = done_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_rst", done_cnt - d0, 0);
        check("bcd_after_rst", bcd_out, 0);
        start_conv(12'd321, 16'h0321, BLANK_ON ? 4'b1000 : 4'b0000);

        // Exhaustive sweep against the divide-by-10 model.
        for (int v = 0; v < 4096; v++) begin
            start_conv(12'(v), ref_bcd(v), ref_mask(v));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
